// File: rtl/input_pkg.sv
// Shared definitions for board input readers: FSM state encoding and the
// default timing constants for the 6 MHz internal oscillator.
package input_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DB_PRESS   = 2'd1,
        PRESSED    = 2'd2,
        DB_RELEASE = 2'd3
    } btn_state_t;

    // 10 ms debounce window and 1 s long-press threshold at 6 MHz
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 60000;
    localparam int unsigned DEF_LONG_CYCLES     = 6000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for an asynchronous pad; the reset value lets the
// caller choose which level is seen while the design comes out of reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic sync_p0;
    logic sync_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/button_input_reader.sv
// Debounced pushbutton reader: synchronises the pad, filters bounce, and
// reports a clean level, press/release/long-press pulses and a press count.
module button_input_reader
    import input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEF_LONG_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1,
    parameter int unsigned COUNT_W         = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               btn_in,
    input  logic               clear_count,
    output logic               level,
    output logic               press_pulse,
    output logic               release_pulse,
    output logic               long_pulse,
    output logic [COUNT_W-1:0] press_count
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int LONG_W = $clog2(LONG_CYCLES);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic p;
    logic s;

    btn_state_t         state, state_n;
    logic [DB_W-1:0]    dbcnt, dbcnt_n;
    logic [LONG_W-1:0]  longcnt, longcnt_n;
    logic               long_done, long_done_n;
    logic               level_n, press_n, release_n, long_n;
    logic [COUNT_W-1:0] count_n;

    // Normalise so 1 always means pressed; the synchroniser then resets to
    // the released level and no press can appear straight out of reset.
    assign p = btn_in ^ ACTIVE_LOW;

    sync_2ff #(.RST_VAL(1'b0)) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (p),
        .q      (s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            dbcnt         <= '0;
            longcnt       <= '0;
            long_done     <= 1'b0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= '0;
        end else begin
            state         <= state_n;
            dbcnt         <= dbcnt_n;
            longcnt       <= longcnt_n;
            long_done     <= long_done_n;
            level         <= level_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            press_count   <= count_n;
        end
    end

    always_comb begin
        state_n     = state;
        dbcnt_n     = dbcnt;
        longcnt_n   = longcnt;
        long_done_n = long_done;
        level_n     = level;
        press_n     = 1'b0;
        release_n   = 1'b0;
        long_n      = 1'b0;
        // Clear is applied first so a press in the same cycle still counts.
        count_n     = clear_count ? '0 : press_count;

        unique case (state)
            IDLE: begin
                if (s) begin
                    state_n = DB_PRESS;
                    dbcnt_n = '0;
                end
            end
            DB_PRESS: begin
                if (!s) begin
                    state_n = IDLE;
                end else if (dbcnt == DB_LAST) begin
                    state_n   = PRESSED;
                    level_n   = 1'b1;
                    press_n   = 1'b1;
                    count_n   = count_n + COUNT_W'(1);
                    longcnt_n = '0;
                end else begin
                    dbcnt_n = dbcnt + DB_W'(1);
                end
            end
            PRESSED, DB_RELEASE: begin
                // Hold time keeps accruing through a release glitch.
                if (longcnt != LONG_LAST)
                    longcnt_n = longcnt + LONG_W'(1);
                if (longcnt == LONG_LAST && !long_done) begin
                    long_n      = 1'b1;
                    long_done_n = 1'b1;
                end
                if (state == PRESSED) begin
                    if (!s) begin
                        state_n = DB_RELEASE;
                        dbcnt_n = '0;
                    end
                end else if (s) begin
                    state_n = PRESSED;
                end else if (dbcnt == DB_LAST) begin
                    state_n     = IDLE;
                    level_n     = 1'b0;
                    release_n   = 1'b1;
                    long_done_n = 1'b0;
                end else begin
                    dbcnt_n = dbcnt + DB_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_button_input_reader.sv
// Directed bench for button_input_reader with short debounce/long timings.
module tb_button_input_reader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       btn_in;
    logic       clear_count;
    logic       level;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    int nchk = 0;
    int npass = 0;
    int n_press = 0;
    int n_release = 0;
    int n_long = 0;
    int snap_p, snap_r, snap_l;

    button_input_reader #(
        .DEBOUNCE_CYCLES (8),
        .LONG_CYCLES     (32),
        .ACTIVE_LOW      (1'b1),
        .COUNT_W         (8)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .btn_in        (btn_in),
        .clear_count   (clear_count),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (press_pulse)   n_press++;
        if (release_pulse) n_release++;
        if (long_pulse)    n_long++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        resetn      = 1'b0;
        btn_in      = 1'b1;
        clear_count = 1'b0;
        tick(3);
        chk("rst_level", level, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        chk("rst_long", long_pulse, 0);
        chk("rst_count", press_count, 0);
        resetn = 1'b1;
        tick(12);
        chk("post_rst_level", level, 0);
        chk("post_rst_npress", n_press, 0);

        // Clean press: pulse 10 cycles after the sampling edge
        btn_in = 1'b0;
        tick(10);
        chk("clean_press_early", press_pulse, 0);
        chk("clean_level_early", level, 0);
        tick(1);
        chk("clean_press", press_pulse, 1);
        chk("clean_level", level, 1);
        chk("clean_count", press_count, 1);
        tick(1);
        chk("clean_press_one_cycle", press_pulse, 0);
        tick(8);
        btn_in = 1'b1;
        tick(10);
        chk("clean_rel_early", release_pulse, 0);
        chk("clean_rel_level_early", level, 1);
        tick(1);
        chk("clean_release", release_pulse, 1);
        chk("clean_rel_level", level, 0);
        tick(1);
        chk("clean_release_one_cycle", release_pulse, 0);
        chk("clean_no_long", n_long, 0);

        // Bounce: toggle every 3 cycles, settle released
        snap_p = n_press; snap_r = n_release; snap_l = n_long;
        for (int i = 0; i < 10; i++) begin
            btn_in = i[0];
            tick(3);
        end
        btn_in = 1'b1;
        tick(20);
        chk("bounce_npress", n_press - snap_p, 0);
        chk("bounce_nrelease", n_release - snap_r, 0);
        chk("bounce_nlong", n_long - snap_l, 0);
        chk("bounce_level", level, 0);
        chk("bounce_count", press_count, 1);

        // Long press: long_pulse 32 cycles after press_pulse
        snap_l = n_long;
        btn_in = 1'b0;
        tick(11);
        chk("long_press", press_pulse, 1);
        chk("long_count", press_count, 2);
        tick(31);
        chk("long_early", long_pulse, 0);
        tick(1);
        chk("long_pulse", long_pulse, 1);
        tick(1);
        chk("long_one_cycle", long_pulse, 0);
        tick(16);
        btn_in = 1'b1;
        tick(10);
        chk("long_rel_early", release_pulse, 0);
        tick(1);
        chk("long_release", release_pulse, 1);
        tick(4);
        chk("long_nlong", n_long - snap_l, 1);

        // Release glitch while pressed
        snap_r = n_release; snap_l = n_long;
        btn_in = 1'b0;
        tick(11);
        chk("glitch_press", press_pulse, 1);
        chk("glitch_count", press_count, 3);
        tick(9);
        btn_in = 1'b1;
        tick(4);
        btn_in = 1'b0;
        tick(18);
        chk("glitch_long_early", long_pulse, 0);
        chk("glitch_level", level, 1);
        chk("glitch_nrelease", n_release - snap_r, 0);
        tick(1);
        chk("glitch_long", long_pulse, 1);
        btn_in = 1'b1;
        tick(11);
        chk("glitch_release", release_pulse, 1);
        tick(2);
        chk("glitch_nlong", n_long - snap_l, 1);

        // Counter wrap
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clear_count", press_count, 0);
        for (int i = 0; i < 255; i++) begin
            btn_in = 1'b0;
            tick(12);
            btn_in = 1'b1;
            tick(12);
        end
        chk("count_255", press_count, 255);
        btn_in = 1'b0;
        tick(12);
        btn_in = 1'b1;
        tick(12);
        chk("count_wrap", press_count, 0);

        // Clear on the same cycle as an accepted press
        btn_in = 1'b0;
        tick(5);
        btn_in = 1'b1;
        tick(12);
        btn_in = 1'b0;
        tick(12);
        btn_in = 1'b1;
        tick(12);
        chk("pre_clear_count", press_count, 1);
        btn_in = 1'b0;
        tick(10);
        clear_count = 1'b1;
        tick(1);
        clear_count = 1'b0;
        chk("clear_press_pulse", press_pulse, 1);
        chk("clear_press_count", press_count, 1);
        btn_in = 1'b1;
        tick(12);

        // Reset mid-press with the pad still held
        btn_in = 1'b0;
        tick(12);
        chk("mid_level", level, 1);
        chk("mid_count", press_count, 2);
        snap_r = n_release;
        resetn = 1'b0;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_count", press_count, 0);
        chk("mid_rst_press", press_pulse, 0);
        @(negedge clk);
        tick(1);
        resetn = 1'b1;
        tick(10);
        chk("rearm_press_early", press_pulse, 0);
        tick(1);
        chk("rearm_press", press_pulse, 1);
        chk("rearm_count", press_count, 1);
        chk("rearm_level", level, 1);
        tick(5);
        chk("rearm_nrelease", n_release - snap_r, 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
